// File: rtl/register_file_pkg.sv
// Shared constants and index type for the scoreboarded register file.
// The fixed indices are the stack pointer and the per-core ID register.
package register_file_pkg;

    localparam int unsigned STACK_INDEX = 0;
    localparam int unsigned ID_INDEX    = 1;

    localparam int unsigned ADDR_WIDTH_RF_DEFAULT = 4;

    typedef logic [ADDR_WIDTH_RF_DEFAULT-1:0] reg_index_t;

endpackage

// File: rtl/register_scoreboard.sv
// Per-register pending scoreboard: tracks operands still owed by long-latency ops,
// derives per-port operand readiness and flags double reservations.
module register_scoreboard
    import register_file_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH_RF = 4,
    parameter int unsigned READ_PORTS    = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                gen_write_effective,
    input  logic [ADDR_WIDTH_RF-1:0]            write_address,
    input  logic                                stack_write_enable,
    input  logic [READ_PORTS*ADDR_WIDTH_RF-1:0] read_address,
    input  logic                                reserve_enable,
    input  logic [ADDR_WIDTH_RF-1:0]            reserve_address,
    output logic [READ_PORTS-1:0]               read_ready,
    output logic                                reserve_conflict,
    output logic [2**ADDR_WIDTH_RF-1:0]         pending
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH_RF;
    localparam logic [ADDR_WIDTH_RF-1:0] STACK_ADDR = ADDR_WIDTH_RF'(STACK_INDEX);

    logic [DEPTH-1:0] clear_vec;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] pending_next;
    logic             conflict_next;

    always_comb begin
        clear_vec = '0;
        set_vec   = '0;
        if (gen_write_effective) clear_vec[write_address] = 1'b1;
        if (stack_write_enable)  clear_vec[STACK_ADDR]    = 1'b1;
        if (reserve_enable)      set_vec[reserve_address] = 1'b1;
    end

    // Set is ORed in after the clear so a same-cycle reserve wins.
    assign pending_next  = (pending & ~clear_vec) | set_vec;
    assign conflict_next = reserve_enable && pending[reserve_address]
                           && !clear_vec[reserve_address];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending          <= '0;
            reserve_conflict <= 1'b0;
        end else begin
            pending          <= pending_next;
            reserve_conflict <= conflict_next;
        end
    end

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_ready
        logic [ADDR_WIDTH_RF-1:0] ra;
        assign ra            = read_address[i*ADDR_WIDTH_RF +: ADDR_WIDTH_RF];
        assign read_ready[i] = !pending[ra] || clear_vec[ra];
    end

endmodule

// File: rtl/scoreboarded_register_file.sv
// General-purpose register file with N combinational read ports, write bypass,
// protected per-core ID register and a pending scoreboard for the issue stage.
module scoreboarded_register_file
    import register_file_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH_RF = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned READ_PORTS    = 2,
    parameter int unsigned CORE_ID       = 0,
    parameter bit          PROTECT_ID    = 1'b1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                general_register_write_enable,
    input  logic [ADDR_WIDTH_RF-1:0]            write_address,
    input  logic [DATA_WIDTH-1:0]               general_register_write_data,
    input  logic                                stack_write_enable,
    input  logic [DATA_WIDTH-1:0]               stack_register_write_data,
    input  logic [READ_PORTS*ADDR_WIDTH_RF-1:0] read_address,
    output logic [READ_PORTS*DATA_WIDTH-1:0]    read_data,
    output logic [READ_PORTS-1:0]               read_ready,
    input  logic                                reserve_enable,
    input  logic [ADDR_WIDTH_RF-1:0]            reserve_address,
    output logic                                reserve_conflict,
    output logic [2**ADDR_WIDTH_RF-1:0]         pending,
    output logic [DATA_WIDTH-1:0]               id
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH_RF;
    localparam logic [ADDR_WIDTH_RF-1:0] STACK_ADDR = ADDR_WIDTH_RF'(STACK_INDEX);
    localparam logic [ADDR_WIDTH_RF-1:0] ID_ADDR    = ADDR_WIDTH_RF'(ID_INDEX);
    localparam logic [DATA_WIDTH-1:0]    ID_RESET   = DATA_WIDTH'(CORE_ID);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  gen_write_effective;

    assign gen_write_effective = general_register_write_enable
                                 && !(PROTECT_ID && (write_address == ID_ADDR));

    // Stack write is applied last so it wins a same-cycle collision on index 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
            regs[ID_ADDR] <= ID_RESET;
        end else begin
            if (gen_write_effective) regs[write_address] <= general_register_write_data;
            if (stack_write_enable)  regs[STACK_ADDR]    <= stack_register_write_data;
        end
    end

    assign id = regs[ID_ADDR];

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_read
        logic [ADDR_WIDTH_RF-1:0] ra;
        assign ra = read_address[i*ADDR_WIDTH_RF +: ADDR_WIDTH_RF];
        assign read_data[i*DATA_WIDTH +: DATA_WIDTH] =
            (stack_write_enable && (ra == STACK_ADDR))     ? stack_register_write_data :
            (gen_write_effective && (ra == write_address)) ? general_register_write_data :
                                                             regs[ra];
    end

    register_scoreboard #(
        .ADDR_WIDTH_RF(ADDR_WIDTH_RF),
        .READ_PORTS   (READ_PORTS)
    ) u_scoreboard (
        .clk                (clk),
        .reset              (reset),
        .gen_write_effective(gen_write_effective),
        .write_address      (write_address),
        .stack_write_enable (stack_write_enable),
        .read_address       (read_address),
        .reserve_enable     (reserve_enable),
        .reserve_address    (reserve_address),
        .read_ready         (read_ready),
        .reserve_conflict   (reserve_conflict),
        .pending            (pending)
    );

endmodule
